fifo_fwft_reader: RTL and testbench
===================================

# fifo_fwft_reader

Read-side drain stage placed directly downstream of `sync_fifo_srl`. It issues reads against the FIFO's standard (registered, one-cycle-latency) read port and re-presents the words as a first-word-fall-through valid/ready stream. A two-entry output buffer sustains one word per clock under continuous `i_ready`, and no word is lost or duplicated under any backpressure pattern.

## Interface
- `FIFO_WIDTH`, default 8: data width; must match the upstream FIFO.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_fifo_empty`  in  1  upstream FIFO `o_empty`.
- `o_fifo_rd`  out  1  read strobe to the upstream FIFO `i_rd`.
- `iv_fifo_dout`  in  FIFO_WIDTH  upstream FIFO `ov_dout`; valid the cycle after `o_fifo_rd`.
- `o_valid`  out  1  `ov_data` holds a word.
- `ov_data`  out  FIFO_WIDTH  oldest buffered word.
- `i_ready`  in  1  consumer accepts the word this cycle.
- `ov_word_cnt`  out  32  accepted-word count. Present only with `FIFO_RD_CNT_EN`.

## Operation
- State registers:
  - `occ`: occupancy, 0..2.
  - `inflight`: 1 when a read was issued in the previous cycle.
  - `head`: drives `ov_data`.
  - `skid`: second entry.
- `pop = o_valid & i_ready`.
- Read issue is combinational: `o_fifo_rd = ~i_fifo_empty & (occ + inflight - pop <= 1)`.
  - The upstream FIFO's flags update at the same edge as the read, so the block never reads an empty FIFO.
- Each edge:
  - `inflight <= o_fifo_rd`.
  - If `inflight` is set, `iv_fifo_dout` is captured.
- Capture placement:
  - Into `head` if `occ == 0`, or if `occ == 1` and `pop`.
  - Otherwise into `skid`.
- On `pop` with `occ == 2`, `skid` moves to `head`. This happens in the same edge as any capture, and the capture then goes to `skid`.
- `occ` update: `occ <= occ + inflight - pop`. It never exceeds 2, which is guaranteed by the read-issue rule.
- `o_valid = (occ != 0)`, driven from a register.
- Word order out equals FIFO order.
- `ov_data` is held stable while `o_valid & ~i_ready`.
- Reset: asynchronous assertion clears all of the following immediately:
  - `occ = 0`, `inflight = 0`, `head = 0`, `skid = 0`, `o_valid = 0`, `ov_data = 0`.
  - `o_fifo_rd = 0`; it is forced low while reset is low.
  - `ov_word_cnt = 0`.
- Reset mid-operation discards buffered and in-flight words. The upstream FIFO is reset by the same system reset.

## Timing
- Latency:
  - `i_fifo_empty` falls in cycle 0 (buffer empty) → `o_fifo_rd` = 1 in cycle 0.
  - Word captured at the end of cycle 1.
  - `o_valid` = 1 in cycle 2.
- Throughput: one word per cycle with `i_ready` held high and the FIFO non-empty.
- Backpressure:
  - `i_ready` low with `occ == 1` and `inflight` set: the in-flight word goes to `skid` and `o_fifo_rd` drops.
  - After `i_ready` returns: `head` and then `skid` are delivered on consecutive cycles.
  - Reads resume in the same cycle `pop` occurs.
- Simultaneous capture and pop: handled in one edge without a bubble.
- The FIFO going empty mid-stream produces no spurious `o_valid`.
- Reset release: first possible `o_fifo_rd` is in the first cycle after `reset` deasserts.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `ov_word_cnt` exists.
  - It increments by 1 on every `pop` and wraps from 0xFFFF_FFFF to 0.
  - Cleared by reset.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset with FIFO holding 0x11,0x22,0x33 → `o_valid`=0 and `o_fifo_rd`=0 during reset. After release with `i_ready`=1: first `o_fifo_rd` at cycle 0, `o_valid` at cycle 2, outputs 0x11,0x22,0x33 on consecutive cycles. `ov_word_cnt`=3.
- FIFO pre-filled with 16 words, `i_ready` held 1 → 16 consecutive valid beats with no bubble; data matches the write order.
- `i_ready` toggling pseudo-randomly over 200 words → scoreboard shows no loss, no duplication, and `ov_data` stable while stalled. `occ` never reaches 3.
- Stall: `i_ready`=0 for 10 cycles with the FIFO non-empty → exactly 2 words buffered and `o_fifo_rd` low after the second read. On release, both words are delivered back-to-back.
- Single word written into an idle FIFO → exactly one `o_fifo_rd` pulse and exactly one valid beat. No read is issued while `i_fifo_empty`=1.
- `reset` asserted asynchronously mid-burst with `occ`=2 → `o_valid`, `ov_data` and `ov_word_cnt` go to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/fifo_fwft_reader.sv
// Read-side drain for sync_fifo_srl: turns the registered FIFO read port into a
// first-word-fall-through valid/ready stream. Optional FIFO_RD_CNT_EN adds ov_word_cnt.
module fifo_fwft_reader #(
    parameter int FIFO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    input  logic [FIFO_WIDTH-1:0] iv_fifo_dout,
    output logic                  o_valid,
    output logic [FIFO_WIDTH-1:0] ov_data,
    input  logic                  i_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [31:0]           ov_word_cnt
`endif
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] skid_q, skid_d;
    logic                  valid_q, valid_d;
    logic                  pop;
    logic [2:0]            pending;

    // pending = words owned after this edge (buffered + arriving - leaving); a read
    // is only safe when that leaves room for the word it will return.
    always_comb begin
        pop       = valid_q & i_ready;
        pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        o_fifo_rd = reset & ~i_fifo_empty & (pending <= 3'd1);
    end

    // NOTE: every signal assigned in this block gets a default first so no latch
    // is inferred on paths that leave it untouched.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = pending[1:0];
        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        if (inflight_q) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                head_d = iv_fifo_dout;
            end else begin
                skid_d = iv_fifo_dout;
            end
        end
        valid_d = (occ_d != 2'd0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; head/skid are reset too because ov_data must read 0 in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= o_fifo_rd;
            head_q     <= head_d;
            skid_q     <= skid_d;
            valid_q    <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign ov_data = head_q;

`ifdef FIFO_RD_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Wraps naturally from 0xFFFF_FFFF to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ov_word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Bench for fifo_fwft_reader: behavioural registered-read FIFO upstream, directed
// cycle table, hand sequences and a scoreboard run. Define FIFO_RD_CNT_EN to check the counter.
module tb_fifo_fwft_reader;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_fifo_empty = 1'b1;
    logic         o_fifo_rd;
    logic [W-1:0] iv_fifo_dout = '0;
    logic         o_valid;
    logic [W-1:0] ov_data;
    logic         i_ready;
`ifdef FIFO_RD_CNT_EN
    logic [31:0]  ov_word_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic         wr_en    = 1'b0;
    logic [W-1:0] wr_data  = '0;
    logic         fifo_clr = 1'b0;
    logic [W-1:0] fifo_q[$];
    int           rd_empty_cnt = 0;

    always #5 clk = ~clk;

    fifo_fwft_reader #(.FIFO_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .iv_fifo_dout (iv_fifo_dout),
        .o_valid      (o_valid),
        .ov_data      (ov_data),
        .i_ready      (i_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .ov_word_cnt  (ov_word_cnt)
`endif
    );

    // Upstream FIFO: read data and empty flag both update on the edge of the read.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
            i_fifo_empty <= 1'b1;
        end else begin
            if (o_fifo_rd) begin
                if (fifo_q.size() == 0) rd_empty_cnt <= rd_empty_cnt + 1;
                else iv_fifo_dout <= fifo_q.pop_front();
            end
            if (wr_en) fifo_q.push_back(wr_data);
            i_fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic step(input logic wr, input logic [W-1:0] d, input logic rdy);
        @(posedge clk);
        #1;
        wr_en   = wr;
        wr_data = d;
        i_ready = rdy;
        @(negedge clk);
    endtask

    task automatic release_reset(input logic rdy);
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        i_ready  = rdy;
        @(negedge clk);
    endtask

    typedef struct {
        logic         wr;
        logic [W-1:0] wdata;
        logic         rdy;
        logic         exp_rd;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[24];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           rd_cnt;
        int           written;
        int           received;
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic [W-1:0] exp_q[$];
        logic         occ_bad;

        // single word, 4-word stall, then ready toggling around a skid capture
        vecs[0]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b1, 8'hB1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB2};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB3};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB4};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[16] = '{1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[17] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC1};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC2};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC2};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

        // Reset held while the FIFO fills with 0x11, 0x22, 0x33
        reset   = 1'b1;
        i_ready = 1'b0;
        #2 reset = 1'b0;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("rst_rd_forced_low", 32'(o_fifo_rd), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(ov_data), 32'd0);
        release_reset(1'b1);
        check("rel_c0_rd", 32'(o_fifo_rd), 32'd1);
        check("rel_c0_valid", 32'(o_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("rel_c1_valid", 32'(o_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("rel_c2_valid", 32'(o_valid), 32'd1);
        check("rel_c2_data", 32'(ov_data), 32'h11);
        step(1'b0, 8'h00, 1'b1);
        check("rel_c3_data", 32'(ov_data), 32'h22);
        step(1'b0, 8'h00, 1'b1);
        check("rel_c4_data", 32'(ov_data), 32'h33);
        step(1'b0, 8'h00, 1'b1);
        check("rel_c5_valid", 32'(o_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("cnt_after_3", ov_word_cnt, 32'd3);
`endif

        // Directed cycle table
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].wr, vecs[i].wdata, vecs[i].rdy);
            check($sformatf("vec%0d_rd", i), 32'(o_fifo_rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(ov_data), 32'(vecs[i].exp_data));
        end
`ifdef FIFO_RD_CNT_EN
        check("cnt_after_table", ov_word_cnt, 32'd10);
`endif

        // 16 words prefilled under reset, drained with ready held high
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(32'h40 + i), 1'b1);
        release_reset(1'b1);
        check("burst_c0_rd", 32'(o_fifo_rd), 32'd1);
        check("burst_c0_valid", 32'(o_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("burst_c1_valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("burst_beat%0d_valid", i), 32'(o_valid), 32'd1);
            check($sformatf("burst_beat%0d_data", i), 32'(ov_data), 32'h40 + 32'(i));
        end
        step(1'b0, 8'h00, 1'b1);
        check("burst_end_valid", 32'(o_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("cnt_after_burst", ov_word_cnt, 32'd16);
`endif

        // Ten-cycle stall: only two reads issued, then back-to-back delivery
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(32'hD0 + i), 1'b0);
            if (o_fifo_rd) rd_cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (o_fifo_rd) rd_cnt++;
        end
        check("stall_rd_count", 32'(rd_cnt), 32'd2);
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_head", 32'(ov_data), 32'hD0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("unstall_beat%0d_valid", i), 32'(o_valid), 32'd1);
            check($sformatf("unstall_beat%0d_data", i), 32'(ov_data), 32'hD0 + 32'(i));
        end
        step(1'b0, 8'h00, 1'b1);
        check("unstall_end_valid", 32'(o_valid), 32'd0);

        // Random writes and backpressure against a scoreboard
        written    = 0;
        received   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        occ_bad    = 1'b0;
        for (int cyc = 0; cyc < 4000 && received < 200; cyc++) begin
            logic         wr;
            logic         rdy;
            logic [W-1:0] d;
            wr  = (written < 200) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            d   = 8'(written * 7 + 3);
            step(wr, d, rdy);
            if (wr) begin
                exp_q.push_back(d);
                written++;
            end
            if (dut.occ_q == 2'd3) occ_bad = 1'b1;
            if (prev_stall) begin
                check("sb_hold_valid", 32'(o_valid), 32'd1);
                check("sb_hold_data", 32'(ov_data), 32'(prev_data));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra_word: got %0h with nothing expected", ov_data);
                end else begin
                    check("sb_data", 32'(ov_data), 32'(exp_q.pop_front()));
                end
                received++;
            end
            prev_stall = o_valid & ~i_ready;
            prev_data  = ov_data;
        end
        check("sb_received", 32'(received), 32'd200);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        check("occ_never_3", 32'(occ_bad), 32'd0);

        // Asynchronous reset mid-burst with both entries full
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check("pre_arst_valid", 32'(o_valid), 32'd1);
        check("pre_arst_data", 32'(ov_data), 32'hE0);
`ifdef FIFO_RD_CNT_EN
        check("pre_arst_cnt", ov_word_cnt, 32'd221);
`endif
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_data", 32'(ov_data), 32'd0);
        check("arst_rd", 32'(o_fifo_rd), 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("arst_cnt", ov_word_cnt, 32'd0);
`endif
        fifo_clr = 1'b1;
        release_reset(1'b1);
        check("post_arst_rd", 32'(o_fifo_rd), 32'd0);
        check("post_arst_valid", 32'(o_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("post_arst_idle", 32'(o_valid), 32'd0);

        check("no_read_when_empty", 32'(rd_empty_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
